seq_gen: RTL and testbench

- Moore-type serial pattern generator: the transmit end of the serial bit-stream that our sequence detectors consume.
- Captures a WIDTH-bit pattern on a start request. Shifts it out MSB-first on dout, one bit per clk, optionally repeated.
- Raises a one-cycle done pulse when finished.
- Drives a detector's din directly in lab setups and benches, replacing hand-written din delay chains.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_piso.sv | 37 +++
 rtl/seq_gen.sv | 159 +++++++++++++++
 tb/tb_seq_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared state codes and constants for the serial pattern generator and the sequence detectors.
// Benches decode stat through these codes so generator and detectors read the same way.
package seq_pkg;
  localparam int STAT_W = 3;

  localparam logic [STAT_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STAT_W-1:0] ST_SHIFT = 3'd1;
  localparam logic [STAT_W-1:0] ST_GAP   = 3'd2;
  localparam logic [STAT_W-1:0] ST_PAR   = 3'd3;
  localparam logic [STAT_W-1:0] ST_DONE  = 3'd4;

  // Line level driven on dout whenever no frame bit is being sent.
  localparam logic IDLE_LVL = 1'b0;
endpackage

// File: rtl/seq_piso.sv
// Loadable WIDTH-bit parallel-in/serial-out shift register, MSB first; load wins over shift.
// Zero latency from register to msb_o; no backpressure, shifts on every shift_i cycle.
module seq_piso
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      sh_d = {sh_q[WIDTH-2:0], IDLE_LVL};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Moore serial pattern generator: start accepted at edge n puts pattern MSB on dout in the next cycle.
// No backpressure; start ignored while busy. Optional per-frame parity bit under SEQGEN_PARITY_EN.
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4,
  parameter int GAP      = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [REPEAT_W-1:0] repeat_n,
  output logic                dout,
  output logic                dvalid,
  output logic                busy,
  output logic                done,
  output logic [STAT_W-1:0]   stat
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  logic [STAT_W-1:0]   state_q, state_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0]    frame_q, frame_d;
  logic                load, shift, frame_end, reload, msb;
  logic [WIDTH-1:0]    load_dat;

  seq_piso #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .clr     (clr),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (load_dat),
    .msb_o   (msb)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    rep_d     = rep_q;
    frame_d   = frame_q;
    load      = 1'b0;
    shift     = 1'b0;
    load_dat  = frame_q;
    frame_end = 1'b0;
    reload    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          load_dat = pattern;
          frame_d  = pattern;
          rep_d    = (repeat_n == '0) ? REPEAT_W'(1) : repeat_n;
          bit_d    = BIT_LAST;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_q != '0) begin
          bit_d = bit_q - BIT_W'(1);
        end else begin
`ifdef SEQGEN_PARITY_EN
          state_d = ST_PAR;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SEQGEN_PARITY_EN
      ST_PAR: frame_end = 1'b1;
`endif
      ST_GAP: begin
        if (gap_q == '0) begin
          reload = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A finished frame either pauses, restarts immediately, or ends the burst.
    if (frame_end) begin
      if (rep_q > REPEAT_W'(1) && GAP > 0) begin
        state_d = ST_GAP;
        gap_d   = GAP_INIT;
      end else if (rep_q > REPEAT_W'(1)) begin
        reload = 1'b1;
      end else begin
        state_d = ST_DONE;
      end
    end

    if (reload) begin
      load     = 1'b1;
      load_dat = frame_q;
      rep_d    = rep_q - REPEAT_W'(1);
      bit_d    = BIT_LAST;
      state_d  = ST_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    dout   = IDLE_LVL;
    dvalid = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        dout   = msb;
        dvalid = 1'b1;
        busy   = 1'b1;
      end
      ST_GAP: busy = 1'b1;
`ifdef SEQGEN_PARITY_EN
      ST_PAR: begin
        dout   = ^frame_q;
        dvalid = 1'b1;
        busy   = 1'b1;
      end
`endif
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign stat = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with GAP=1, one with GAP=0, shared clock/reset.
module tb_seq_gen;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0, start0 = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] repeat_n = 4'd0;
  logic       dout, dvalid, busy, done;
  logic       dout0, dvalid0, busy0, done0;
  logic [2:0] stat, stat0;

  int errors = 0;
  int checks = 0;

  seq_gen #(.WIDTH(8), .REPEAT_W(4), .GAP(1)) dut (
    .clk(clk), .clr(clr), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .dout(dout), .dvalid(dvalid), .busy(busy), .done(done), .stat(stat)
  );

  seq_gen #(.WIDTH(8), .REPEAT_W(4), .GAP(0)) dut0 (
    .clk(clk), .clr(clr), .start(start0), .pattern(pattern), .repeat_n(repeat_n),
    .dout(dout0), .dvalid(dvalid0), .busy(busy0), .done(done0), .stat(stat0)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    #3;
    checks++; if ({dout, dvalid, busy, done} !== 4'b0000) begin errors++; $display("FAIL por_outputs got=%b want=0000", {dout, dvalid, busy, done}); end
    checks++; if (stat !== ST_IDLE) begin errors++; $display("FAIL por_stat got=%0d want=0", stat); end
    tick; clr = 1'b1; tick;
    // Mid-frame reset: 8'hA5, drop clr during cycle 4 (bit 3).
    pattern = 8'hA5; repeat_n = 4'd0; start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick;
    checks++; if (stat !== ST_SHIFT) begin errors++; $display("FAIL rst_pre_stat got=%0d want=1", stat); end
    clr = 1'b0;
    #1;
    checks++; if ({dout, dvalid, busy, done} !== 4'b0000) begin errors++; $display("FAIL rst_mid_outputs got=%b want=0000", {dout, dvalid, busy, done}); end
    checks++; if (stat !== ST_IDLE) begin errors++; $display("FAIL rst_mid_stat got=%0d want=0", stat); end
    tick; clr = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (done || dvalid || busy || stat !== ST_IDLE) seen = 1'b1;
        tick;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_idle_hold got=activity want=idle"); end
    end
  endtask

  task automatic test_single;
    logic [8:0] dv, vv, dn, bz;
    logic [2:0] st1;
    pattern = 8'b1101_0010; repeat_n = 4'd0; start = 1'b1;
    tick; start = 1'b0; pattern = 8'h00;
    st1 = stat;
    for (int c = 0; c < 9; c++) begin
      dv = {dv[7:0], dout}; vv = {vv[7:0], dvalid}; dn = {dn[7:0], done}; bz = {bz[7:0], busy};
      tick;
    end
    checks++; if (st1 !== ST_SHIFT) begin errors++; $display("FAIL single_stat1 got=%0d want=1", st1); end
    checks++; if (dv !== 9'b110100100) begin errors++; $display("FAIL single_dout got=%b want=110100100", dv); end
    checks++; if (vv !== 9'b111111110) begin errors++; $display("FAIL single_dvalid got=%b want=111111110", vv); end
    checks++; if (dn !== 9'b000000001) begin errors++; $display("FAIL single_done got=%b want=000000001", dn); end
    checks++; if (bz !== 9'b111111111) begin errors++; $display("FAIL single_busy got=%b want=111111111", bz); end
    checks++; if ({busy, stat} !== 4'b0000) begin errors++; $display("FAIL single_after got=%b want=0000", {busy, stat}); end
  endtask

  task automatic test_repeat_gap;
    logic [26:0] dv, vv, dn;
    logic [2:0] st9;
    pattern = 8'hF0; repeat_n = 4'd3; start = 1'b1;
    tick; start = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      if (c == 9) st9 = stat;
      dv = {dv[25:0], dout}; vv = {vv[25:0], dvalid}; dn = {dn[25:0], done};
      tick;
    end
    checks++; if (dv !== 27'b11110000_0_11110000_0_11110000_0) begin errors++; $display("FAIL gap_dout got=%b", dv); end
    checks++; if (vv !== 27'b11111111_0_11111111_0_11111111_0) begin errors++; $display("FAIL gap_dvalid got=%b", vv); end
    checks++; if (dn !== 27'd1) begin errors++; $display("FAIL gap_done got=%b want=done at 27", dn); end
    checks++; if (st9 !== ST_GAP) begin errors++; $display("FAIL gap_stat9 got=%0d want=2", st9); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_after_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [16:0] dv, vv, dn;
    pattern = 8'h81; repeat_n = 4'd2; start0 = 1'b1;
    tick; start0 = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      dv = {dv[15:0], dout0}; vv = {vv[15:0], dvalid0}; dn = {dn[15:0], done0};
      tick;
    end
    checks++; if (dv !== 17'b1000000110000001_0) begin errors++; $display("FAIL b2b_dout got=%b", dv); end
    checks++; if (vv !== 17'b1111111111111111_0) begin errors++; $display("FAIL b2b_dvalid got=%b", vv); end
    checks++; if (dn !== 17'd1) begin errors++; $display("FAIL b2b_done got=%b want=done at 17", dn); end
    checks++; if ({busy0, stat0} !== 4'b0000) begin errors++; $display("FAIL b2b_after got=%b want=0000", {busy0, stat0}); end
  endtask

  task automatic test_start_held;
    logic [18:0] dv, vv, dn;
    logic [2:0] st9, st10;
    pattern = 8'h3C; repeat_n = 4'd0; start = 1'b1;
    tick;
    for (int c = 1; c <= 19; c++) begin
      if (c == 9)  st9 = stat;
      if (c == 10) st10 = stat;
      dv = {dv[17:0], dout}; vv = {vv[17:0], dvalid}; dn = {dn[17:0], done};
      if (c == 4)  pattern = 8'hFF;
      if (c == 12) start = 1'b0;
      tick;
    end
    checks++; if (dv !== 19'b00111100_0_0_11111111_0) begin errors++; $display("FAIL held_dout got=%b", dv); end
    checks++; if (vv !== 19'b11111111_0_0_11111111_0) begin errors++; $display("FAIL held_dvalid got=%b", vv); end
    checks++; if (dn !== 19'b00000000_1_0_00000000_1) begin errors++; $display("FAIL held_done got=%b", dn); end
    checks++; if ({st9, st10} !== {ST_DONE, ST_IDLE}) begin errors++; $display("FAIL held_stat got=%0d,%0d want=4,0", st9, st10); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_after_busy got=%b want=0", busy); end
  endtask

  task automatic test_parity(input logic [7:0] pat, input logic [8:0] want_dv);
    logic [9:0] dv, vv, dn;
    logic [2:0] st9;
    pattern = pat; repeat_n = 4'd0; start = 1'b1;
    tick; start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 9) st9 = stat;
      dv = {dv[8:0], dout}; vv = {vv[8:0], dvalid}; dn = {dn[8:0], done};
      tick;
    end
    checks++; if (dv !== {want_dv, 1'b0}) begin errors++; $display("FAIL par_dout pat=%h got=%b want=%b0", pat, dv, want_dv); end
    checks++; if (vv !== 10'b1111111110) begin errors++; $display("FAIL par_dvalid got=%b", vv); end
    checks++; if (dn !== 10'd1) begin errors++; $display("FAIL par_done got=%b", dn); end
    checks++; if (st9 !== ST_PAR) begin errors++; $display("FAIL par_stat9 got=%0d want=3", st9); end
  endtask

  initial begin
    test_reset;
`ifdef SEQGEN_PARITY_EN
    test_parity(8'h07, 9'b00000111_1);
    test_parity(8'h03, 9'b00000011_0);
`else
    test_single;
    test_repeat_gap;
    test_back_to_back;
    test_start_held;
`endif
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
